idma_desc64_reg_submitter: RTL and testbench

Register-bus initiator that feeds 64-bit descriptor addresses into the desc64 frontend's register file. It buffers addresses arriving on a valid/ready stream and turns each into a regbus write to the DESC_ADDR register, holding the request until the frontend asserts ready. This is how the frontend applies backpressure while its descriptor FIFO is full. It also issues on-demand status reads. It sits in a host-side or cluster-side controller, upstream of the frontend's regbus port.

---
 rtl/idma_desc64_submit_pkg.sv | 28 ++
 rtl/idma_desc64_addr_buffer.sv | 67 ++++++
 rtl/idma_desc64_reg_submitter.sv | 150 +++++++++++++++
 tb/tb_idma_desc64_reg_submitter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/idma_desc64_submit_pkg.sv
// Shared types and constants for the desc64 regbus submitter.
// Offsets mirror the desc64 frontend register file layout.
package idma_desc64_submit_pkg;

    localparam logic [63:0] IDMA_DESC64_DESC_ADDR_OFFSET = 64'h0;
    localparam logic [63:0] IDMA_DESC64_STATUS_OFFSET    = 64'h8;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_WRITE = 2'd1;
    localparam state_t ST_READ  = 2'd2;
    localparam state_t ST_ERROR = 2'd3;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        logic        valid;
    } submit_reg_req_t;

    typedef struct packed {
        logic [63:0] rdata;
        logic        error;
        logic        ready;
    } submit_reg_rsp_t;

endpackage

// File: rtl/idma_desc64_addr_buffer.sv
// Depth x Width synchronous FIFO holding descriptor addresses awaiting submission.
// Pushes when full and pops when empty are ignored; head is visible combinationally.
module idma_desc64_addr_buffer #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntWidth = $clog2(Depth + 1);

    typedef logic [PtrWidth-1:0] ptr_t;
    localparam ptr_t LastPtr = ptr_t'(Depth - 1);

    logic [Width-1:0]    r_mem [Depth];
    ptr_t                r_wr_ptr;
    ptr_t                r_rd_ptr;
    logic [CntWidth-1:0] r_count;
    logic                w_push;
    logic                w_pop;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == LastPtr) ? '0 : p + ptr_t'(1);
    endfunction

    assign full_o  = (r_count == CntWidth'(Depth));
    assign empty_o = (r_count == '0);
    assign data_o  = r_mem[r_rd_ptr];
    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CntWidth'(1);
                2'b01:   r_count <= r_count - CntWidth'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: emptiness is tracked by the count alone.
    always_ff @(posedge clk_i) begin
        if (w_push && !rst_i) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

endmodule

// File: rtl/idma_desc64_reg_submitter.sv
// Turns buffered descriptor addresses into regbus DESC_ADDR writes and serves STATUS polls.
// Write request appears two cycles after a push; the request is held until the frontend raises ready.
module idma_desc64_reg_submitter
    import idma_desc64_submit_pkg::*;
#(
    parameter type         reg_req_t      = idma_desc64_submit_pkg::submit_reg_req_t,
    parameter type         reg_rsp_t      = idma_desc64_submit_pkg::submit_reg_rsp_t,
    parameter logic [63:0] BaseAddr       = 64'h0,
    parameter logic [63:0] DescAddrOffset = IDMA_DESC64_DESC_ADDR_OFFSET,
    parameter logic [63:0] StatusOffset   = IDMA_DESC64_STATUS_OFFSET,
    parameter int unsigned Depth          = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [63:0] desc_addr_i,
    input  logic        desc_valid_i,
    output logic        desc_ready_o,
    input  logic        poll_valid_i,
    output logic        poll_ready_o,
    output logic        status_valid_o,
    output logic [63:0] status_rdata_o,
    output reg_req_t    reg_req_o,
    input  reg_rsp_t    reg_rsp_i,
    output logic        err_o,
    output logic [63:0] err_addr_o,
    input  logic        err_clear_i,
    output logic        busy_o
);

    state_t      r_state;
    logic        r_last_was_read;
    reg_req_t    r_req;
    logic        r_status_vld;
    logic [63:0] r_status_rdata;
    logic        r_err;
    logic [63:0] r_err_addr;

    logic        w_push;
    logic        w_pop;
    logic        w_full;
    logic        w_empty;
    logic [63:0] w_head;
    logic        w_idle;
    logic        w_sel_write;
    logic        w_sel_read;

    localparam int unsigned AddrWidth  = $bits(r_req.addr);
    localparam logic [63:0] DescAddr   = BaseAddr + DescAddrOffset;
    localparam logic [63:0] StatusAddr = BaseAddr + StatusOffset;

    idma_desc64_addr_buffer #(
        .Depth (Depth),
        .Width (64)
    ) i_addr_buffer (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_push),
        .data_i  (desc_addr_i),
        .pop_i   (w_pop),
        .data_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    assign desc_ready_o = !w_full && !rst_i;
    assign w_push       = desc_valid_i && desc_ready_o;
    assign w_pop        = (r_state == ST_WRITE) && reg_rsp_i.ready;

    // A pending poll only wins over a queued write when the previous grant was a write.
    assign w_idle       = (r_state == ST_IDLE);
    assign w_sel_write  = w_idle && !w_empty && (!poll_valid_i || r_last_was_read);
    assign w_sel_read   = w_idle && !w_sel_write && poll_valid_i;
    assign poll_ready_o = w_sel_read && !rst_i;

    assign reg_req_o      = r_req;
    assign status_valid_o = r_status_vld;
    assign status_rdata_o = r_status_rdata;
    assign err_o          = r_err;
    assign err_addr_o     = r_err_addr;
    assign busy_o         = !w_empty || (r_state == ST_WRITE) || (r_state == ST_READ);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state         <= ST_IDLE;
            r_last_was_read <= 1'b0;
            r_req           <= '0;
            r_status_vld    <= 1'b0;
            r_status_rdata  <= '0;
            r_err           <= 1'b0;
            r_err_addr      <= '0;
        end else begin
            r_status_vld <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_sel_write) begin
                        r_req.valid <= 1'b1;
                        r_req.write <= 1'b1;
                        r_req.addr  <= DescAddr[AddrWidth-1:0];
                        r_req.wdata <= w_head;
                        r_req.wstrb <= '1;
                        r_state     <= ST_WRITE;
                    end else if (w_sel_read) begin
                        r_req.valid <= 1'b1;
                        r_req.write <= 1'b0;
                        r_req.addr  <= StatusAddr[AddrWidth-1:0];
                        r_req.wdata <= '0;
                        r_req.wstrb <= '0;
                        r_state     <= ST_READ;
                    end
                end
                ST_WRITE: begin
                    if (reg_rsp_i.ready) begin
                        r_req.valid     <= 1'b0;
                        r_last_was_read <= 1'b0;
                        if (reg_rsp_i.error) begin
                            r_err      <= 1'b1;
                            r_err_addr <= w_head;
                            r_state    <= ST_ERROR;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_READ: begin
                    if (reg_rsp_i.ready) begin
                        r_req.valid     <= 1'b0;
                        r_last_was_read <= 1'b1;
                        r_status_vld    <= 1'b1;
                        r_status_rdata  <= reg_rsp_i.rdata;
                        if (reg_rsp_i.error) begin
                            r_err      <= 1'b1;
                            r_err_addr <= '0;
                            r_state    <= ST_ERROR;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_ERROR: begin
                    if (err_clear_i) begin
                        r_err   <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_idma_desc64_reg_submitter.sv
// Directed bench: cycle table for the write stream and write/read alternation,
// plus hand sequences for stalls, fill, bus error and reset.
module tb_idma_desc64_reg_submitter;
    import idma_desc64_submit_pkg::*;

    localparam logic [63:0] BASE  = 64'h0000_0000_4000_0000;
    localparam logic [31:0] WADDR = 32'h4000_0000;
    localparam logic [31:0] RADDR = 32'h4000_0008;

    logic            clk;
    logic            rst;
    logic [63:0]     da;
    logic            dv;
    logic            desc_ready;
    logic            pv;
    logic            poll_ready;
    logic            status_valid;
    logic [63:0]     status_rdata;
    submit_reg_req_t reg_req;
    submit_reg_rsp_t reg_rsp;
    logic            rr;
    logic            re;
    logic [63:0]     rd;
    logic            err;
    logic [63:0]     err_addr;
    logic            ec;
    logic            busy;

    assign reg_rsp.ready = rr;
    assign reg_rsp.error = re;
    assign reg_rsp.rdata = rd;

    idma_desc64_reg_submitter #(
        .BaseAddr (BASE),
        .Depth    (4)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .desc_addr_i    (da),
        .desc_valid_i   (dv),
        .desc_ready_o   (desc_ready),
        .poll_valid_i   (pv),
        .poll_ready_o   (poll_ready),
        .status_valid_o (status_valid),
        .status_rdata_o (status_rdata),
        .reg_req_o      (reg_req),
        .reg_rsp_i      (reg_rsp),
        .err_o          (err),
        .err_addr_o     (err_addr),
        .err_clear_i    (ec),
        .busy_o         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        vld;
        logic        wr;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        logic        drdy;
        logic        prdy;
        logic        svld;
        logic [63:0] srd;
        logic        err;
        logic        busy;
    } out_t;

    typedef struct {
        logic        dv;
        logic [63:0] da;
        logic        pv;
        out_t        exp;
    } vec_t;

    int          n_chk;
    int          n_fail;
    int          nreq;
    bit          done;
    logic [63:0] got[$];
    vec_t        tbl[18];
    out_t        act;

    task automatic chk(input string name, input logic [127:0] a, input logic [127:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, a, e);
        end
    endtask

    function automatic vec_t mkv(input logic v_dv, input logic [63:0] v_da, input logic v_pv,
                                 input logic vld, input logic wr, input logic [63:0] wd,
                                 input logic drdy, input logic prdy, input logic svld,
                                 input logic bsy);
        vec_t v;
        v.dv        = v_dv;
        v.da        = v_da;
        v.pv        = v_pv;
        v.exp       = '0;
        v.exp.vld   = vld;
        v.exp.wr    = vld & wr;
        v.exp.addr  = vld ? (wr ? WADDR : RADDR) : 32'h0;
        v.exp.wdata = (vld & wr) ? wd : 64'h0;
        v.exp.wstrb = (vld & wr) ? 8'hFF : 8'h00;
        v.exp.drdy  = drdy;
        v.exp.prdy  = prdy;
        v.exp.svld  = svld;
        v.exp.srd   = svld ? 64'hA5 : 64'h0;
        v.exp.busy  = bsy;
        return v;
    endfunction

    function automatic out_t sample();
        out_t o;
        o     = '0;
        o.vld = reg_req.valid;
        if (reg_req.valid) begin
            o.wr    = reg_req.write;
            o.addr  = reg_req.addr;
            o.wstrb = reg_req.wstrb;
            if (reg_req.write) o.wdata = reg_req.wdata;
        end
        o.drdy = desc_ready;
        o.prdy = poll_ready;
        o.svld = status_valid;
        if (status_valid) o.srd = status_rdata;
        o.err  = err;
        o.busy = busy;
        return o;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; dv = 1'b0; pv = 1'b0; rr = 1'b0; re = 1'b0; ec = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Always-ready responder; collects wdata of every write that completes cleanly.
    task automatic drain_writes(input int budget);
        got.delete();
        done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge clk);
            dv = 1'b0; rr = 1'b1; re = 1'b0; #1;
            if (reg_req.valid && reg_req.write) got.push_back(reg_req.wdata);
            if (!busy) done = 1'b1;
        end
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        rst = 1'b1; dv = 1'b1; da = 64'h1234; pv = 1'b1;
        rr = 1'b0; re = 1'b0; rd = 64'hA5; ec = 1'b0;

        //                dv  da            pv  vld wr wdata         drdy prdy svld busy
        tbl[0]  = mkv(1, 64'h1000, 0,  0, 0, 64'h0,    1, 0, 0, 0);
        tbl[1]  = mkv(1, 64'h2000, 0,  0, 0, 64'h0,    1, 0, 0, 1);
        tbl[2]  = mkv(1, 64'h3000, 0,  1, 1, 64'h1000, 1, 0, 0, 1);
        tbl[3]  = mkv(0, 64'h0,    0,  0, 0, 64'h0,    1, 0, 0, 1);
        tbl[4]  = mkv(0, 64'h0,    0,  1, 1, 64'h2000, 1, 0, 0, 1);
        tbl[5]  = mkv(0, 64'h0,    0,  0, 0, 64'h0,    1, 0, 0, 1);
        tbl[6]  = mkv(0, 64'h0,    0,  1, 1, 64'h3000, 1, 0, 0, 1);
        tbl[7]  = mkv(0, 64'h0,    0,  0, 0, 64'h0,    1, 0, 0, 0);
        tbl[8]  = mkv(1, 64'h5000, 0,  0, 0, 64'h0,    1, 0, 0, 0);
        tbl[9]  = mkv(1, 64'h6000, 0,  0, 0, 64'h0,    1, 0, 0, 1);
        tbl[10] = mkv(0, 64'h0,    1,  1, 1, 64'h5000, 1, 0, 0, 1);
        tbl[11] = mkv(0, 64'h0,    1,  0, 0, 64'h0,    1, 1, 0, 1);
        tbl[12] = mkv(0, 64'h0,    1,  1, 0, 64'h0,    1, 0, 0, 1);
        tbl[13] = mkv(0, 64'h0,    1,  0, 0, 64'h0,    1, 0, 1, 1);
        tbl[14] = mkv(0, 64'h0,    1,  1, 1, 64'h6000, 1, 0, 0, 1);
        tbl[15] = mkv(0, 64'h0,    1,  0, 0, 64'h0,    1, 1, 0, 0);
        tbl[16] = mkv(0, 64'h0,    0,  1, 0, 64'h0,    1, 0, 0, 1);
        tbl[17] = mkv(0, 64'h0,    0,  0, 0, 64'h0,    1, 0, 1, 0);

        // Reset values, with push and poll requests held high to show they are blocked.
        @(negedge clk);
        @(negedge clk); #1;
        chk("rst_desc_ready", desc_ready, 0);
        chk("rst_poll_ready", poll_ready, 0);
        chk("rst_req_valid", reg_req.valid, 0);
        chk("rst_status_valid", status_valid, 0);
        chk("rst_status_rdata", status_rdata, 0);
        chk("rst_err", err, 0);
        chk("rst_err_addr", err_addr, 0);
        chk("rst_busy", busy, 0);

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            rst = 1'b0; dv = tbl[i].dv; da = tbl[i].da; pv = tbl[i].pv;
            rr = 1'b1; re = 1'b0; rd = 64'hA5; #1;
            act = sample();
            n_chk++;
            if (act !== tbl[i].exp) begin
                n_fail++;
                $display("FAIL table[%0d]: got %h, expected %h", i, act, tbl[i].exp);
            end
        end

        // Ten-cycle stall on the first write.
        do_reset();
        @(negedge clk); dv = 1'b1; da = 64'h1000; #1;
        @(negedge clk); dv = 1'b0; #1;
        chk("lat_t1_idle", reg_req.valid, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); rr = 1'b0; #1;
            chk("stall_hold", {reg_req.valid, reg_req.write, reg_req.addr, reg_req.wdata, reg_req.wstrb},
                {1'b1, 1'b1, WADDR, 64'h1000, 8'hFF});
        end
        @(negedge clk); rr = 1'b1; #1;
        chk("stall_complete_cycle", reg_req.valid, 1);
        @(negedge clk); rr = 1'b0; #1;
        chk("stall_after_vld", reg_req.valid, 0);
        chk("stall_after_busy", busy, 0);

        // Fill Depth+1 entries with ready low.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); dv = 1'b1; da = 64'hA000 + 64'(k) * 64'h100; rr = 1'b0; #1;
            chk("fill_desc_ready", desc_ready, k < 4);
        end
        @(negedge clk); rr = 1'b1; #1;
        chk("full_before_pop", desc_ready, 0);
        chk("fill_head_wdata", reg_req.wdata, 64'hA000);
        @(negedge clk); rr = 1'b0; #1;
        chk("ready_after_pop", desc_ready, 1);
        drain_writes(60);
        chk("fill_drain_done", done, 1);
        chk("fill_drain_count", got.size(), 4);
        for (int i = 0; i < got.size() && i < 4; i++)
            chk("fill_drain_order", got[i], 64'hA100 + 64'(i) * 64'h100);

        // Error on the second write.
        do_reset();
        got.delete();
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            dv = (c < 3); da = 64'h1000 * 64'(c + 1); rr = 1'b1;
            re = reg_req.valid && reg_req.write && (reg_req.wdata == 64'h2000); #1;
            if (reg_req.valid && !re) got.push_back(reg_req.wdata);
            if (err) done = 1'b1;
        end
        dv = 1'b0;
        chk("err_seen", done, 1);
        chk("err_addr", err_addr, 64'h2000);
        chk("err_prior_writes", got.size(), 1);
        nreq = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); rr = 1'b1; re = 1'b0; #1;
            if (reg_req.valid) nreq++;
        end
        chk("err_no_requests", nreq, 0);
        chk("err_sticky", err, 1);
        @(negedge clk); ec = 1'b1; #1;
        @(negedge clk); ec = 1'b0; #1;
        chk("err_cleared", err, 0);
        drain_writes(40);
        chk("err_resume_done", done, 1);
        chk("err_resume_count", got.size(), 1);
        chk("err_resume_wdata", (got.size() > 0) ? got[0] : 64'h0, 64'h3000);

        // Reset while a write is stalled.
        do_reset();
        @(negedge clk); dv = 1'b1; da = 64'h1000; rr = 1'b0; #1;
        @(negedge clk); dv = 1'b1; da = 64'h2000; #1;
        @(negedge clk); dv = 1'b0; #1;
        chk("rst_mid_pre_valid", reg_req.valid, 1);
        @(negedge clk); rst = 1'b1; pv = 1'b1; dv = 1'b1; #1;
        chk("rst_mid_desc_ready", desc_ready, 0);
        chk("rst_mid_poll_ready", poll_ready, 0);
        @(negedge clk); rst = 1'b0; pv = 1'b0; dv = 1'b0; #1;
        chk("rst_mid_valid", reg_req.valid, 0);
        chk("rst_mid_busy", busy, 0);
        nreq = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); rr = 1'b1; #1;
            if (reg_req.valid) nreq++;
        end
        chk("rst_mid_buffer_empty", nreq, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
